// File: rtl/graph_node_config_writer_pkg.sv
// rtl/graph_node_config_writer_pkg.sv - shared widths, FSM states and slot helper for the node config writer
package graph_forge_pkg;

    localparam int NODE_ID_WIDTH = 8;
    localparam int WEIGHT_WIDTH  = 16;
    localparam int MAX_DEGREE    = 15;
    localparam int SLOTS         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // LSB position of a slot inside a flattened per-slot bus
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/graph_node_config_writer_if.sv
// rtl/graph_node_config_writer_if.sv - edge-record stream between the edge-list feeder and the writer
interface graph_node_config_writer_if #(
    parameter int NODE_ID_WIDTH = graph_forge_pkg::NODE_ID_WIDTH,
    parameter int WEIGHT_WIDTH  = graph_forge_pkg::WEIGHT_WIDTH
) ();

    logic                     edge_valid;
    logic                     edge_ready;
    logic [NODE_ID_WIDTH-1:0] edge_node_id;
    logic [NODE_ID_WIDTH-1:0] edge_neighbor_id;
    logic [WEIGHT_WIDTH-1:0]  edge_weight;
    logic [NODE_ID_WIDTH-1:0] edge_partition_id;
    logic                     edge_last;

    modport master (
        output edge_valid, edge_node_id, edge_neighbor_id, edge_weight,
               edge_partition_id, edge_last,
        input  edge_ready
    );

    modport slave (
        input  edge_valid, edge_node_id, edge_neighbor_id, edge_weight,
               edge_partition_id, edge_last,
        output edge_ready
    );

endinterface

// File: rtl/graph_node_config_writer_edge_buffer.sv
// rtl/graph_node_config_writer_edge_buffer.sv - per-slot neighbor id / weight register file with clear-all
module graph_edge_buffer #(
    parameter int SLOTS         = graph_forge_pkg::SLOTS,
    parameter int NODE_ID_WIDTH = graph_forge_pkg::NODE_ID_WIDTH,
    parameter int WEIGHT_WIDTH  = graph_forge_pkg::WEIGHT_WIDTH,
    parameter int IDX_WIDTH     = $clog2(SLOTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [IDX_WIDTH-1:0]             wr_idx,
    input  logic [NODE_ID_WIDTH-1:0]         wr_id,
    input  logic [WEIGHT_WIDTH-1:0]          wr_weight,
    output logic [SLOTS*NODE_ID_WIDTH-1:0]   rd_ids,
    output logic [SLOTS*WEIGHT_WIDTH-1:0]    rd_weights
);
    import graph_forge_pkg::*;

    logic [NODE_ID_WIDTH-1:0] ids     [SLOTS];
    logic [WEIGHT_WIDTH-1:0]  weights [SLOTS];

    // Clear wipes every slot; a write in the same cycle lands on top of the cleared buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                ids[i]     <= '0;
                weights[i] <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < SLOTS; i++) begin
                    ids[i]     <= '0;
                    weights[i] <= '0;
                end
            end
            if (wr_en) begin
                ids[wr_idx]     <= wr_id;
                weights[wr_idx] <= wr_weight;
            end
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_flat
        assign rd_ids[slot_lsb(g, NODE_ID_WIDTH) +: NODE_ID_WIDTH]    = ids[g];
        assign rd_weights[slot_lsb(g, WEIGHT_WIDTH) +: WEIGHT_WIDTH]  = weights[g];
    end

endmodule

// File: rtl/graph_node_config_writer.sv
// rtl/graph_node_config_writer.sv - collects per-node edge records and commits them to a graph-node cell
module graph_node_config_writer #(
    parameter int NODE_ID_WIDTH = graph_forge_pkg::NODE_ID_WIDTH,
    parameter int WEIGHT_WIDTH  = graph_forge_pkg::WEIGHT_WIDTH,
    parameter int MAX_DEGREE    = graph_forge_pkg::MAX_DEGREE,
    parameter int SLOTS         = graph_forge_pkg::SLOTS
) (
    input  logic                             clk,
    input  logic                             rst,
    graph_node_config_writer_if.slave        edge_in,
    output logic [NODE_ID_WIDTH-1:0]         cfg_node_id,
    output logic                             cfg_enable,
    output logic [3:0]                       cfg_degree,
    output logic [SLOTS*NODE_ID_WIDTH-1:0]   cfg_neighbor_ids,
    output logic [SLOTS*WEIGHT_WIDTH-1:0]    cfg_edge_weights,
    output logic [NODE_ID_WIDTH-1:0]         cfg_partition_id,
    output logic                             cfg_partition_update,
    output logic                             busy,
    output logic                             err_overflow,
    output logic                             err_node_mismatch,
    output logic [15:0]                      nodes_written
);
    import graph_forge_pkg::*;

    state_t                   state;
    logic [3:0]               count;
    logic [NODE_ID_WIDTH-1:0] node_q;
    logic [NODE_ID_WIDTH-1:0] part_q;
    logic                     ready_q;
    logic                     commit_q;

    logic       accept;
    logic       node_match;
    logic       full;
    logic       buf_clr;
    logic       buf_wr;
    logic [3:0] buf_idx;

    assign accept     = edge_in.edge_valid && ready_q;
    assign node_match = (edge_in.edge_node_id == node_q);
    assign full       = (count == 4'(MAX_DEGREE));

    // First accept of a node restarts the buffer at slot 0; later accepts append unless dropped
    always_comb begin
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        buf_idx = count;
        if (accept && state == IDLE) begin
            buf_clr = 1'b1;
            buf_wr  = 1'b1;
            buf_idx = 4'd0;
        end else if (accept && state == COLLECT && node_match && !full) begin
            buf_wr  = 1'b1;
        end
    end

    graph_edge_buffer #(
        .SLOTS         (SLOTS),
        .NODE_ID_WIDTH (NODE_ID_WIDTH),
        .WEIGHT_WIDTH  (WEIGHT_WIDTH),
        .IDX_WIDTH     (4)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .clr        (buf_clr),
        .wr_en      (buf_wr),
        .wr_idx     (buf_idx),
        .wr_id      (edge_in.edge_neighbor_id),
        .wr_weight  (edge_in.edge_weight),
        .rd_ids     (cfg_neighbor_ids),
        .rd_weights (cfg_edge_weights)
    );

    // Collection FSM: the commit strobe and the one-cycle ready bubble are registered off the last accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            count             <= 4'd0;
            node_q            <= '0;
            part_q            <= '0;
            ready_q           <= 1'b0;
            commit_q          <= 1'b0;
            err_overflow      <= 1'b0;
            err_node_mismatch <= 1'b0;
            nodes_written     <= 16'd0;
        end else begin
            ready_q  <= !(accept && edge_in.edge_last);
            commit_q <= accept && edge_in.edge_last;
            case (state)
                IDLE: begin
                    if (accept) begin
                        node_q <= edge_in.edge_node_id;
                        part_q <= edge_in.edge_partition_id;
                        count  <= 4'd1;
                        state  <= edge_in.edge_last ? COMMIT : COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (!node_match) begin
                            err_node_mismatch <= 1'b1;
                        end else if (full) begin
                            err_overflow <= 1'b1;
                        end else begin
                            count <= count + 4'd1;
                        end
                        if (edge_in.edge_last) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
            if (accept && edge_in.edge_last && nodes_written != 16'hFFFF) begin
                nodes_written <= nodes_written + 16'd1;
            end
        end
    end

    assign edge_in.edge_ready   = ready_q;
    assign cfg_enable           = commit_q;
    assign cfg_partition_update = commit_q;
    assign cfg_degree           = count;
    assign cfg_node_id          = node_q;
    assign cfg_partition_id     = part_q;
    assign busy                 = (state != IDLE);

endmodule

// File: doc/graph_node_config_writer.md
Name: graph_node_config_writer

Overview:
- Streaming loader that drives the configuration side of one graph-node cell.
- Accepts a valid/ready stream of edge records grouped per node and buffers up to 15 edges.
- On the node's last record, issues a single-cycle commit: node id, degree, neighbor list, edge weights and partition assignment.
- Sits between the host/DMA edge-list feeder and the graph-node array. It is the writer for the node cell's inputs.

Parameters:
- NODE_ID_WIDTH, 8, width of node and partition identifiers.
- WEIGHT_WIDTH, 16, width of one edge weight.
- MAX_DEGREE, 15, maximum stored edges per node (fixed by the node's 4-bit degree field).
- SLOTS, 16, neighbor/weight slots driven to the node cell.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- edge_valid  in  1  record valid
- edge_ready  out  1  record accepted when valid&ready
- edge_node_id  in  NODE_ID_WIDTH  node owning this edge
- edge_neighbor_id  in  NODE_ID_WIDTH  neighbor id
- edge_weight  in  WEIGHT_WIDTH  edge weight
- edge_partition_id  in  NODE_ID_WIDTH  partition; sampled on the first record of a node only
- edge_last  in  1  final record of this node
- cfg_node_id  out  NODE_ID_WIDTH  target node
- cfg_enable  out  1  one-cycle commit strobe
- cfg_degree  out  4  stored edge count
- cfg_neighbor_ids  out  SLOTS*NODE_ID_WIDTH  flattened; slot i at bits [i*W +: W]
- cfg_edge_weights  out  SLOTS*WEIGHT_WIDTH  flattened, same slot layout
- cfg_partition_id  out  NODE_ID_WIDTH  partition for the node
- cfg_partition_update  out  1  high together with cfg_enable
- busy  out  1  state != IDLE
- err_overflow  out  1  sticky: edges beyond MAX_DEGREE were dropped
- err_node_mismatch  out  1  sticky: record node id differed from the node being collected
- nodes_written  out  16  commits issued, saturating at 0xFFFF

Behaviour:
- Reset: every output is 0, buffer slots are 0, state is IDLE. Reset mid-collection discards the partial node; no commit is issued.
- FSM states are IDLE, COLLECT and COMMIT.
- IDLE:
  - edge_ready=1.
  - On accept: latch node_id and partition_id, zero all slots, write slot 0, count=1.
  - If edge_last, go to COMMIT; otherwise go to COLLECT.
- COLLECT:
  - edge_ready=1.
  - On accept with node_id != latched id: the record is consumed and dropped, and err_node_mismatch is set. Its edge_last is still honoured.
  - On accept with count==MAX_DEGREE: the record is dropped and err_overflow is set. edge_last is honoured.
  - Otherwise: write slot[count], then count++.
  - If edge_last, go to COMMIT.
- COMMIT:
  - Lasts exactly one cycle, with edge_ready=0.
  - cfg_enable=1 and cfg_partition_update=1.
  - cfg_degree=count; cfg_node_id and cfg_partition_id take the latched values.
  - nodes_written increments (saturating).
  - Next state is IDLE.
- Latency: last record accepted in cycle N gives cfg_enable high in cycle N+1. The earliest next accept is cycle N+2, i.e. one bubble per node.
- Slot contents:
  - cfg_* buses are driven from the buffer registers and hold their last committed values until the next node's first accept.
  - Slots at index >= degree are 0 during commit.
  - cfg_* buses are only meaningful while cfg_enable=1.
- Arithmetic: count is 4 bits and never exceeds 15. Weights are passed through unmodified; the writer does no summing.
- Error flags are cleared only by rst.

Decomposition:
- Package graph_forge_pkg holds:
  - NODE_ID_WIDTH, WEIGHT_WIDTH, MAX_DEGREE and SLOTS defaults;
  - the FSM state enum (IDLE/COLLECT/COMMIT);
  - the slot-index helper for flattened buses.
- One sub-module, graph_edge_buffer: SLOTS-entry id/weight register file with clear-all, write-at-index and flattened read buses.

Test Plan:
- Node 5, part 3, records (1,10),(2,20),(7,30,last) -> the next cycle shows:
  - cfg_enable=1, cfg_node_id=5, cfg_degree=3;
  - ids 1,2,7 and weights 10,20,30, slots 3..15 = 0;
  - cfg_partition_update=1, cfg_partition_id=3, nodes_written=1.
- Single record node 0x22 with last on the first beat -> commit the next cycle, degree=1, busy low after.
- 17 records to node 9 -> one commit, degree=15, slots hold the first 15 edges, err_overflow=1.
- Node 4 edge, node 6 edge, node 4 edge last -> degree=2, the node-6 record is absent, err_node_mismatch=1.
- edge_valid held high over two nodes (node 1 with 4 edges, then node 2 with 2 edges) -> edge_ready low for exactly one cycle per commit, and node 2 shows slots 2..15 = 0.
- rst pulsed after 2 accepted edges of node 8 -> no cfg_enable, all outputs 0. A following 1-edge node 8 commits degree=1 with nodes_written=1.
